nibble_serial_addsub: RTL and testbench

NIBBLE_SERIAL_ADDSUB -- requirements
Module: nibble_serial_addsub

---
 rtl/nibble_serial_addsub.sv | 175 +++++++++++++++++
 tb/tb_nibble_serial_addsub.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial 16-bit adder/subtractor.
// One 4-bit carry-lookahead slice per clock, LSB slice first.
module nibble_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ACC_W = WIDTH - SLICE;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [SLICE-1:0]   sl_a;
    logic [SLICE-1:0]   sl_b;
    logic [SLICE-1:0]   sl_g;
    logic [SLICE-1:0]   sl_p;
    logic [SLICE-1:0]   sl_c;
    logic               sl_cout;
    logic [SLICE-1:0]   sl_sum;

    // Pick the operand nibble addressed by the slice counter.
    always_comb begin
        sl_a = a_q[3:0];
        sl_b = b_q[3:0];
        unique case (cnt_q)
            2'd0: begin
                sl_a = a_q[3:0];
                sl_b = b_q[3:0];
            end
            2'd1: begin
                sl_a = a_q[7:4];
                sl_b = b_q[7:4];
            end
            2'd2: begin
                sl_a = a_q[11:8];
                sl_b = b_q[11:8];
            end
            2'd3: begin
                sl_a = a_q[15:12];
                sl_b = b_q[15:12];
            end
            default: begin
                sl_a = a_q[3:0];
                sl_b = b_q[3:0];
            end
        endcase
    end

    // 4-bit carry-lookahead slice; sl_c[3] is the carry into the slice MSB.
    always_comb begin
        sl_g = sl_a & sl_b;
        sl_p = sl_a ^ sl_b;
        sl_c[0] = carry_q;
        sl_c[1] = sl_g[0]
                | (sl_p[0] & carry_q);
        sl_c[2] = sl_g[1]
                | (sl_p[1] & sl_g[0])
                | (sl_p[1] & sl_p[0] & carry_q);
        sl_c[3] = sl_g[2]
                | (sl_p[2] & sl_g[1])
                | (sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[2] & sl_p[1] & sl_p[0] & carry_q);
        sl_cout = sl_g[3]
                | (sl_p[3] & sl_g[2])
                | (sl_p[3] & sl_p[2] & sl_g[1])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
                | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & carry_q);
        sl_sum = sl_p ^ sl_c;
    end

    // Next-state, operand capture, slice accumulation and result load.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                    a_d     = a;
                    // Subtract is a + ~b + ~cin in the same adder.
                    b_d     = op ? ~b : b;
                    carry_d = op ? ~cin : cin;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                carry_d = sl_cout;
                cnt_d   = cnt_q + 2'd1;
                unique case (cnt_q)
                    2'd0: acc_d[3:0]  = sl_sum;
                    2'd1: acc_d[7:4]  = sl_sum;
                    2'd2: acc_d[11:8] = sl_sum;
                    2'd3: begin
                        // Top slice goes straight to the result with flags.
                        state_d = DONE;
                        sum_d   = {sl_sum, acc_q};
                        cout_d  = sl_cout;
                        ovf_d   = sl_c[3] ^ sl_cout;
                    end
                    default: acc_d = acc_q;
                endcase
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: directed vectors, start/reset
// control cases and randomized ops against an arithmetic model.
module tb_nibble_serial_addsub;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int checks;
    int failures;

    nibble_serial_addsub dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {cout, ovf, sum}.
    function automatic logic [17:0] model(input logic o,
                                          input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic ci);
        int ux;
        int uy;
        int sx;
        int sy;
        int ur;
        int sr;
        logic [15:0] s;
        logic c;
        logic v;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (!o) begin
            ur = ux + uy + int'(ci);
            sr = sx + sy + int'(ci);
            c  = (ur > 65535);
        end else begin
            ur = ux - uy - int'(ci);
            sr = sx - sy - int'(ci);
            c  = (ur >= 0);
        end
        s = ur[15:0];
        v = (sr > 32767) || (sr < -32768);
        return {c, v, s};
    endfunction

    // Called at a negedge: issue start with operands, follow the op to done.
    // With hold=1, start stays high and inputs are scrambled during RUN.
    task automatic exec(input string tag, input logic o,
                        input logic [15:0] x, input logic [15:0] y,
                        input logic ci, input bit hold,
                        output logic [15:0] exp_sum);
        logic [17:0] m;
        logic [15:0] prev;
        int nb;
        bit got;
        bit moved;
        m = model(o, x, y, ci);
        exp_sum = m[15:0];
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        cin = ci;
        prev = sum;
        nb = 0;
        got = 0;
        moved = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!hold && i == 0) start = 1'b0;
            if (hold) begin
                a = 16'($urandom);
                b = 16'($urandom);
                op = 1'($urandom);
                cin = 1'($urandom);
            end
            if (i == 0) chk({tag, "_busy0"}, {30'd0, busy, done}, 32'd2);
            if (done) begin
                got = 1;
                break;
            end
            if (busy) nb++;
            if (sum !== prev) moved = 1;
        end
        chk({tag, "_done"}, 32'(got), 32'd1);
        chk({tag, "_busycyc"}, 32'(nb), 32'd4);
        chk({tag, "_hold"}, 32'(moved), 32'd0);
        chk({tag, "_sum"}, {16'd0, sum}, {16'd0, m[15:0]});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, m[17]});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, m[16]});
    endtask

    // One cycle after done with start low: idle, result held.
    task automatic idle_chk(input string tag, input logic [15:0] es);
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_keep"}, {16'd0, sum}, {16'd0, es});
    endtask

    initial begin
        logic [15:0] es;
        bit b2b;
        bit hl;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;

        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_flags", {30'd0, cout, ovf}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort at slice 2: no done, no result update.
        start = 1'b1;
        op = 1'b0;
        a = 16'h1234;
        b = 16'h4321;
        cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_run", {31'd0, busy}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_sum", {16'd0, sum}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit saw;
            saw = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (done || busy) saw = 1;
            end
            chk("abort_quiet", 32'(saw), 32'd0);
            chk("abort_sum2", {16'd0, sum}, 32'd0);
        end

        // Directed vectors, all with explicit expectations.
        exec("add", 1'b0, 16'd10, 16'd15, 1'b1, 1'b0, es);
        chk("add_val", {16'd0, sum, 14'd0, cout, ovf}, {16'h001A, 16'h0000});
        idle_chk("add", es);
        exec("wrap", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, es);
        chk("wrap_val", {sum, 14'd0, cout, ovf}, {16'h0000, 16'h0002});
        idle_chk("wrap", es);
        exec("sovf", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, es);
        chk("sovf_val", {sum, 14'd0, cout, ovf}, {16'h8000, 16'h0001});
        idle_chk("sovf", es);
        exec("subb", 1'b1, 16'h0005, 16'h0007, 1'b0, 1'b0, es);
        chk("subb_val", {sum, 15'd0, cout}, {16'hFFFE, 16'h0000});
        idle_chk("subb", es);
        exec("subn", 1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0, es);
        chk("subn_val", {sum, 14'd0, cout, ovf}, {16'h7FFE, 16'h0003});
        idle_chk("subn", es);

        // start held through RUN with scrambled inputs, then back-to-back.
        exec("holdop", 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b1, es);
        chk("hold_val", {16'd0, sum}, 32'h3333);
        exec("b2b", 1'b1, 16'h0100, 16'h0001, 1'b0, 1'b0, es);
        chk("b2b_val", {16'd0, sum}, 32'h00FF);
        idle_chk("b2b", es);

        // Randomized ops, mixing back-to-back, idle gaps and held start.
        for (int n = 0; n < 24; n++) begin
            hl = ($urandom_range(0, 3) == 0);
            exec("rnd", 1'($urandom), 16'($urandom), 16'($urandom),
                 1'($urandom), hl, es);
            b2b = 1'($urandom);
            if (!b2b) idle_chk("rnd", es);
        end
        idle_chk("end", es);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
